// File: rtl/ps2_kbd_rx_pkg.sv
// +----------------------------------------------------------------------+
// | ps2_kbd_rx_pkg : shared types and constants for the PS/2 receiver     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package ps2_kbd_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // Start + 8 data + parity + stop
  localparam int FRAME_LEN       = 11;
  localparam int DATA_BITS       = FRAME_LEN - 3;
  localparam int DEFAULT_TIMEOUT = 200000;

endpackage

`default_nettype wire

// File: rtl/ps2_kbd_rx_sync_fifo.sv
// +----------------------------------------------------------------------+
// | sync_fifo : first-word-fall-through FIFO with occupancy count         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_rd;
  logic             w_do_wr;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  // A write into a full FIFO is legal when a read frees a slot the same cycle
  assign w_do_rd = i_rd & ~o_empty;
  assign w_do_wr = i_wr & (~o_full | w_do_rd);

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
// +----------------------------------------------------------------------+
// | ps2_kbd_rx : PS/2 keyboard receiver with scan-code FIFO and IRQ       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module ps2_kbd_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    data_out,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  output logic                          irq
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic          r_clk_meta, r_clk_sync;
  logic          r_dat_meta, r_dat_sync;
  logic          r_filt, r_filt_prev;
  logic [FW-1:0] r_filt_cnt;
  logic          w_fall;

  ps2_state_t    r_state;
  logic [2:0]    r_bit_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_shreg;
  logic          r_parity;
  logic          r_push;
  logic [7:0]    r_push_byte;
  logic          r_parity_err;
  logic          r_frame_err;
  logic          r_overflow;

  logic          w_fifo_full;
  logic          w_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_dat_meta  <= 1'b1;
      r_dat_sync  <= 1'b1;
      r_filt      <= 1'b1;
      r_filt_prev <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_clk_meta  <= ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_dat_meta  <= ps2_data;
      r_dat_sync  <= r_dat_meta;
      r_filt_prev <= r_filt;
      // Any sample agreeing with the filtered level restarts the run
      if (r_clk_sync == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt     <= ~r_filt;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  assign w_fall = r_filt_prev & ~r_filt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_to_cnt     <= '0;
      r_shreg      <= '0;
      r_parity     <= 1'b0;
      r_push       <= 1'b0;
      r_push_byte  <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (clr_err) begin
        r_parity_err <= 1'b0;
        r_frame_err  <= 1'b0;
      end
      if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          ST_IDLE: begin
            if (!r_dat_sync) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            r_shreg <= {r_dat_sync, r_shreg[7:1]};
            if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
              r_state <= ST_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          ST_PARITY: begin
            r_parity <= r_dat_sync;
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            if (!r_dat_sync) begin
              r_frame_err <= 1'b1;
            end else if (^{r_shreg, r_parity}) begin
              r_push      <= 1'b1;
              r_push_byte <= r_shreg;
            end else begin
              r_parity_err <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (r_state != ST_IDLE) begin
        if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          r_state     <= ST_IDLE;
          r_to_cnt    <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + TW'(1);
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  // A push into a full FIFO survives only if the CPU pops in the same cycle
  assign w_drop = r_push & w_fifo_full & ~rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else begin
      if (clr_err) r_overflow <= 1'b0;
      if (w_drop)  r_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (r_push & ~w_drop),
    .i_wr_data (r_push_byte),
    .i_rd      (rd_en),
    .o_rd_data (data_out),
    .o_empty   (empty),
    .o_full    (w_fifo_full),
    .o_count   (count)
  );

  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;
  assign irq        = ~empty;

endmodule

`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
// +----------------------------------------------------------------------+
// | tb_ps2_kbd_rx : directed self-checking bench for ps2_kbd_rx           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ps2_kbd_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_out;
  logic       empty;
  logic [3:0] count;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;
  logic       irq;

  int total = 0;
  int bad   = 0;

  ps2_kbd_rx #(
    .FIFO_DEPTH  (8),
    .FILTER_LEN  (8),
    .TIMEOUT_CYC (2000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .data_out   (data_out),
    .empty      (empty),
    .count      (count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_n(25);
    ps2_clk = 1'b0;
    wait_n(50);
    ps2_clk = 1'b1;
    wait_n(25);
  endtask

  // Stop-bit fall lands 10 clk after the pin drops (2 sync + 8 filter);
  // push runs the next cycle, so the byte is visible at negedge 12.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input bit chk_lat, input bit pop_at_push);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_data = stop;
    wait_n(25);
    ps2_clk = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (chk_lat && k == 11) chk("lat_empty_before_push", 32'(empty), 32'd1);
      if (chk_lat && k == 12) chk("lat_empty_after_push", 32'(empty), 32'd0);
      if (pop_at_push && k == 11) rd_en = 1'b1;
      if (pop_at_push && k == 12) rd_en = 1'b0;
    end
    ps2_clk = 1'b1;
    wait_n(25);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  initial begin
    wait_n(5);
    rst = 1'b0;
    wait_n(2);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    // Single good frame with exact push latency
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("f1_data", 32'(data_out), 32'h1C);
    chk("f1_count", 32'(count), 32'd1);
    chk("f1_irq", 32'(irq), 32'd1);
    pop();
    chk("f1_pop_empty", 32'(empty), 32'd1);
    chk("f1_pop_data", 32'(data_out), 32'h00);
    pop();
    chk("underflow_count", 32'(count), 32'd0);
    chk("underflow_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);

    // Bad parity
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("perr_empty", 32'(empty), 32'd1);
    chk("perr_flag", 32'(parity_err), 32'd1);
    chk("perr_no_ferr", 32'(frame_err), 32'd0);
    pulse_clr();
    chk("perr_cleared", 32'(parity_err), 32'd0);

    // Bad stop bit
    send_frame(8'h33, odd_par(8'h33), 1'b0, 1'b0, 1'b0);
    chk("stop0_ferr", 32'(frame_err), 32'd1);
    chk("stop0_empty", 32'(empty), 32'd1);
    pulse_clr();

    // Overflow
    for (int i = 1; i <= 8; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1, 1'b0, 1'b0);
    chk("ovf_count8", 32'(count), 32'd8);
    chk("ovf_not_yet", 32'(overflow), 32'd0);
    send_frame(8'h09, odd_par(8'h09), 1'b1, 1'b0, 1'b0);
    chk("ovf_count_still8", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_pop_data", 32'(data_out), 32'(i));
      pop();
    end
    chk("ovf_drained", 32'(empty), 32'd1);
    pulse_clr();
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Glitch on ps2_clk with data low must not start a frame
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_n(3);
    ps2_clk  = 1'b1;
    wait_n(20);
    ps2_data = 1'b1;
    wait_n(20);
    send_frame(8'h55, odd_par(8'h55), 1'b1, 1'b0, 1'b0);
    chk("glitch_data", 32'(data_out), 32'h55);
    chk("glitch_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);
    pop();

    // Timeout after 4 data bits of 0xF0
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    ps2_data = 1'b1;
    wait_n(1800);
    chk("to_not_yet", 32'(frame_err), 32'd0);
    wait_n(200);
    chk("to_ferr", 32'(frame_err), 32'd1);
    chk("to_empty", 32'(empty), 32'd1);
    pulse_clr();
    send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b0, 1'b0);
    chk("after_to_data", 32'(data_out), 32'hF0);
    chk("after_to_ferr", 32'(frame_err), 32'd0);
    pop();

    // Reset in the middle of a frame, with a byte held and an error pending
    send_frame(8'h12, odd_par(8'h12), 1'b1, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    rst = 1'b1;
    wait_n(2);
    rst = 1'b0;
    ps2_data = 1'b1;
    wait_n(2);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'h00);
    chk("mid_rst_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    wait_n(50);

    // Full FIFO with a pop coincident with the push
    for (int i = 0; i < 8; i++) send_frame(8'h21 + 8'(i), odd_par(8'h21 + 8'(i)), 1'b1, 1'b0, 1'b0);
    chk("sim_full", 32'(count), 32'd8);
    send_frame(8'h29, odd_par(8'h29), 1'b1, 1'b0, 1'b1);
    chk("sim_count", 32'(count), 32'd8);
    chk("sim_no_ovf", 32'(overflow), 32'd0);
    chk("sim_head", 32'(data_out), 32'h22);
    for (int i = 0; i < 8; i++) begin
      chk("sim_pop_data", 32'(data_out), 32'h22 + 32'(i));
      pop();
    end
    chk("sim_drained", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
